rca_seq_adder: RTL and testbench
================================

# rca_seq_adder

Multi-cycle 64-bit adder that reuses one 16-bit ripple-carry slice over four cycles. It is the addition counterpart of the team's 64-bit RCA subtractor. Operands are latched on a start handshake. The carry ripples slice-by-slice through a carry register, and the result, carry-out and signed overflow are presented with a one-cycle done pulse. It sits in the datapath wherever an area-cheap adder with a start/done handshake is preferred over the flat 64-bit RCA. Subtraction is obtained by the caller driving B inverted with cin=1.

## Interface
- WIDTH, 64, operand/result width
- SLICE, 16, bits summed per cycle; WIDTH must be a multiple of SLICE
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- A  in  WIDTH  operand A, sampled with accepted start
- B  in  WIDTH  operand B, sampled with accepted start
- cin  in  1  carry-in, sampled with accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when the result becomes valid
- S  out  WIDTH  sum, registered
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: (A[msb]==B[msb]) && (S[msb]!=A[msb])

## Operation
- One clock. Reset is asynchronous and active-low.
- States: IDLE, RUN. NSLICE = WIDTH/SLICE = 4.
- Accepting a start:
  - In IDLE, start=1 at an edge latches A, B and cin into internal registers.
  - The same edge sets idx=0 and carry=cin, and moves to RUN.
- Each RUN cycle:
  - Slice idx of A and B, plus the carry register, go through the slice adder.
  - The sum is written into bits [idx*SLICE +: SLICE] of an internal accumulator.
  - carry takes the slice carry-out, and idx increments.
- At the RUN edge where idx==NSLICE-1:
  - S is loaded with the full accumulator, including the final slice.
  - cout takes the final carry, and ovf is computed from the latched MSBs and the final sum MSB.
  - done=1 for exactly one cycle, and the state returns to IDLE.
- S, cout and ovf hold their last result until the next completion. Partial sums are never visible on S.
- start while busy=1 is ignored and not queued. A held high start re-triggers in the first IDLE cycle.
- Width rules:
  - Arithmetic is unsigned modulo 2^WIDTH.
  - cout is the true 65th bit.
  - ovf is valid for two's-complement interpretation. With B inverted and cin=1, ovf reports signed subtraction overflow.
- Reset, including mid-operation: state=IDLE, busy=0, done=0, S=0, cout=0, ovf=0, idx=0, carry=0. Any in-flight operation is discarded.

## Timing
- busy = (state==RUN), combinational from the state register.
- Edge E0 accepts start. Edges E1–E4 compute slices 0–3.
- After E4: done=1, busy=0, and S/cout/ovf are valid.
- After E5: done=0.
- Latency is 4 cycles from the accepting edge to done.
- Back-to-back throughput is one operation per 5 cycles: the earliest next acceptance is E5, while done is high.
- Input values are don't-care when no start is being accepted.
- Critical path is one SLICE-bit ripple plus the carry register setup.

## Structure
- Package rca_seq_pkg holds:
  - WIDTH, SLICE and NSLICE localparams.
  - typedef enum logic {IDLE, RUN} state_t.
  - The idx width, $clog2(NSLICE).
- Sub-module rca_slice: combinational SLICE-bit ripple-carry adder built from full-adder cells, with ports a, b, ci, s, co. It is instantiated once.
- Top level contains the FSM, operand registers, index counter, carry register, accumulator and output registers.

## Test plan
- A=1, B=1, cin=0, start pulsed once -> done exactly 4 cycles after acceptance; S=2, cout=0, ovf=0; busy high for 4 cycles.
- A=0x0000_0000_0000_FFFF, B=1 -> S=0x0000_0000_0001_0000, cout=0 (checks carry across slice boundary).
- A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> S=0, cout=1, ovf=0. A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> S=0x8000_0000_0000_0000, ovf=1.
- Subtraction: A=10, B=~3, cin=1 -> S=7, cout=1. A=3, B=~10, cin=1 -> S=0xFFFF_FFFF_FFFF_FFF9, cout=0.
- start re-pulsed at E2 with different operands -> ignored, result is that of the first operands. start held high continuously -> acceptances at E0, E5, E10.
- rst_n asserted between E2 and E3 -> immediately busy=0, done=0, S=0, cout=0. After release, a fresh operation completes correctly with no stale carry.

Source files
------------

// File: rtl/rca_seq_adder_pkg.sv
// rca_seq_pkg: shared parameters and types for the sequential ripple-carry adder.
//   WIDTH  - operand/result width
//   SLICE  - bits summed per cycle by the single slice adder
//   NSLICE - number of slices (cycles) per operation
//   IDX_W  - width of the slice index counter
//   state_t - FSM state encoding (IDLE, RUN)
package rca_seq_pkg;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rca_seq_adder_if.sv
// rca_seq_adder_if: start/done request bundle for rca_seq_adder.
//   start  - request, accepted only when busy=0
//   A, B   - operands, sampled with an accepted start
//   cin    - carry-in, sampled with an accepted start
//   busy   - operation in progress
//   done   - one-cycle pulse when S/cout/ovf become valid
//   S      - registered sum
//   cout   - carry out of bit WIDTH-1
//   ovf    - signed overflow
// Handshake: a request is taken at the rising edge where start=1 and busy=0;
// there is no back-pressure on the result, which is announced by done and
// held on S/cout/ovf until the next completion.
interface rca_seq_adder_if;
  import rca_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output start, A, B, cin,
    input  busy, done, S, cout, ovf
  );

  modport slave (
    input  start, A, B, cin,
    output busy, done, S, cout, ovf
  );

endinterface

// File: rtl/rca_seq_adder_slice.sv
// rca_slice: combinational SLICE-bit ripple-carry adder built from a chain of
// full-adder cells.
//   a, b - slice operands
//   ci   - carry into bit 0
//   s    - slice sum
//   co   - carry out of the top bit
module rca_slice
  import rca_seq_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  // c[i] is the carry into bit i; c[SLICE] leaves the slice.
  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign co = c[SLICE];

endmodule

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: WIDTH-bit adder that reuses one SLICE-bit ripple-carry slice
// over NSLICE cycles. Operands are latched on an accepted start; each RUN
// cycle sums one slice and ripples the carry through carry_q. The final RUN
// edge loads S/cout/ovf and pulses done.
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   bus         - request/result bundle (slave side)
//   dbg_state_o - current FSM state, for observation only
module rca_seq_adder
  import rca_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rca_seq_adder_if.slave    bus,
  output state_t            dbg_state_o
);

  state_t                         state_q;
  logic [NSLICE-1:0][SLICE-1:0]   a_q;
  logic [NSLICE-1:0][SLICE-1:0]   b_q;
  logic [NSLICE-1:0][SLICE-1:0]   acc_q;
  logic [NSLICE-1:0][SLICE-1:0]   acc_d;
  logic [IDX_W-1:0]               idx_q;
  logic                           carry_q;
  logic [WIDTH-1:0]               s_q;
  logic                           cout_q;
  logic                           ovf_q;
  logic                           done_q;

  logic [SLICE-1:0]               slice_s;
  logic                           slice_co;
  logic                           last_slice;

  rca_slice u_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Accumulator with the current slice merged in; on the last slice this is
  // the complete sum, so S can be loaded in the same edge.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = slice_s;
  end

  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= slice_co;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_slice) begin
            s_q     <= acc_d;
            cout_q  <= slice_co;
            // Overflow: operands share a sign that the sum does not.
            ovf_q   <= (a_q[NSLICE-1][SLICE-1] == b_q[NSLICE-1][SLICE-1]) &&
                       (acc_d[NSLICE-1][SLICE-1] != a_q[NSLICE-1][SLICE-1]);
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.S       = s_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: table vectors plus hand-written multi-cycle sequences for
// rca_seq_adder; results are checked through an expected-value queue.
module tb_rca_seq_adder;
  import rca_seq_pkg::*;

  localparam int W = WIDTH + 2;  // {S, cout, ovf}

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  rca_seq_adder_if ifc ();

  rca_seq_adder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[7];

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Independent reference: 65-bit sum plus sign rule.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic c);
    logic [WIDTH:0]   full;
    logic             o;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    o = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {full[WIDTH-1:0], full[WIDTH], o};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && ifc.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        check("result", {ifc.S, ifc.cout, ifc.ovf}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (ifc.busy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (ifc.busy) begin
      n_checks++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  // One operation: checks latency to done and busy duration.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic [W-1:0] exp);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 0;
    wait_idle();
    @(negedge clk);
    ifc.A = a; ifc.B = b; ifc.cin = c; ifc.start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    while (!got && lat < 20) begin
      if (ifc.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (ifc.done) got = 1;
    end
    check("latency", W'(lat), W'(4));
    check("busy_cycles", W'(busy_cnt), W'(4));
    check("busy_at_done", W'(ifc.busy), W'(0));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    logic [WIDTH-1:0] all1;

    all1 = '1;
    vecs[0] = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[2] = '{all1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{64'd10, ~64'd3, 1'b1, 64'd7, 1'b1, 1'b0};
    vecs[5] = '{64'd3, ~64'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};

    ifc.start = 1'b0; ifc.A = '0; ifc.B = '0; ifc.cin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ifc.S, ifc.cout, ifc.ovf}, '0);
    check("reset_busy_done", W'({ifc.busy, ifc.done}), W'(0));
    check("reset_state", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].s, vecs[i].cout, vecs[i].ovf});

    // random vectors against the model
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rc, model(ra, rb, rc));
    end

    // start re-pulsed mid-operation is ignored
    begin
      int n = 0;
      wait_idle();
      @(negedge clk);
      ifc.A = 64'd5; ifc.B = 64'd6; ifc.cin = 1'b0; ifc.start = 1'b1;
      exp_q.push_back(model(64'd5, 64'd6, 1'b0));
      @(posedge clk); #1;          // E0
      ifc.start = 1'b0;
      @(posedge clk);              // E1
      @(negedge clk);
      ifc.A = 64'h1234; ifc.B = 64'h4321; ifc.cin = 1'b1; ifc.start = 1'b1;
      @(posedge clk); #1;          // E2
      ifc.start = 1'b0;
      while (!ifc.done && n < 10) begin
        @(posedge clk); #1; n++;
      end
      check("ignored_start_done_at_E4", W'(n), W'(2));
      repeat (6) @(posedge clk);
      #1;
      check("ignored_start_not_queued", W'({ifc.busy, exp_q.size() != 0}), W'(0));
    end

    // start held high: acceptances at E0, E5, E10
    begin
      logic [W-1:0] e;
      e = model(64'hDEAD_BEEF, 64'h1111_1111_1111_1111, 1'b1);
      wait_idle();
      @(negedge clk);
      ifc.A = 64'hDEAD_BEEF; ifc.B = 64'h1111_1111_1111_1111; ifc.cin = 1'b1;
      ifc.start = 1'b1;
      repeat (3) exp_q.push_back(e);
      for (int k = 0; k <= 14; k++) begin
        @(posedge clk); #1;
        if (k == 10) ifc.start = 1'b0;
        check($sformatf("held_busy_k%0d", k), W'(ifc.busy), W'((k % 5) != 4));
        check($sformatf("held_done_k%0d", k), W'(ifc.done), W'((k % 5) == 4));
      end
    end

    // reset between E2 and E3 discards the operation
    wait_idle();
    @(negedge clk);
    ifc.A = all1; ifc.B = 64'd1; ifc.cin = 1'b0; ifc.start = 1'b1;
    exp_q.push_back(model(all1, 64'd1, 1'b0));
    @(posedge clk); #1;            // E0
    ifc.start = 1'b0;
    @(posedge clk);                // E1
    @(posedge clk);                // E2
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy_done", W'({ifc.busy, ifc.done}), W'(0));
    check("midreset_outputs", {ifc.S, ifc.cout, ifc.ovf}, '0);
    check("midreset_state", W'(dbg_state), W'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, {64'h0000_0000_0001_0000, 1'b0, 1'b0});
    do_op(64'd1, 64'd1, 1'b0, {64'd2, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
